// File: rtl/letc_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a word-wide valid/ready bus, level irq out.
// Optional macro LETC_MTIMER_DBG_HALT_EN adds i_dbg_halt to freeze the prescaler and mtime.
module letc_mtimer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] MTIME_RST = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef LETC_MTIMER_DBG_HALT_EN
  input  logic        i_dbg_halt,
`endif
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_wen_nren,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_timer_irq_pending
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_nxt;
  logic        halt;
  logic        tick;
  logic        access;
  logic        addr_ok;
  logic [15:0] presc_cnt;
  logic [63:0] mtime, mtime_inc, mtime_nxt;
  logic [63:0] mtimecmp, mtimecmp_nxt;
  logic [31:0] rdata_sel, rdata_q;

`ifdef LETC_MTIMER_DBG_HALT_EN
  assign halt = i_dbg_halt;
`else
  assign halt = 1'b0;
`endif

  assign access    = (state == IDLE) && i_valid;
  assign addr_ok   = (i_addr[1:0] == 2'b00);
  assign tick      = !halt && (presc_cnt == PRESC_MAX);
  assign mtime_inc = mtime + 64'(tick);

  // A write to one mtime half overrides only that half of the incremented value.
  always_comb begin
    mtime_nxt    = mtime_inc;
    mtimecmp_nxt = mtimecmp;
    if (access && i_wen_nren && addr_ok) begin
      case (i_addr[3:2])
        2'd0: mtime_nxt[31:0]     = i_wdata;
        2'd1: mtime_nxt[63:32]    = i_wdata;
        2'd2: mtimecmp_nxt[31:0]  = i_wdata;
        2'd3: mtimecmp_nxt[63:32] = i_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_sel = '0;
    if (addr_ok && !i_wen_nren) begin
      case (i_addr[3:2])
        2'd0: rdata_sel = mtime[31:0];
        2'd1: rdata_sel = mtime[63:32];
        2'd2: rdata_sel = mtimecmp[31:0];
        2'd3: rdata_sel = mtimecmp[63:32];
        default: ;
      endcase
    end
  end

  // ---- counter / compare registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_cnt           <= '0;
      mtime               <= MTIME_RST;
      mtimecmp            <= '1;
      o_timer_irq_pending <= 1'b0;
    end else begin
      if (!halt) begin
        presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
      end
      mtime               <= mtime_nxt;
      mtimecmp            <= mtimecmp_nxt;
      o_timer_irq_pending <= (mtime >= mtimecmp);
    end
  end

  // Read data is captured pre-tick; output gating keeps it invisible outside RESP.
  always_ff @(posedge i_clk) begin
    if (access) begin
      rdata_q <= rdata_sel;
    end
  end

  // ---- bus FSM ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_rdata = '0;
    if (state == RESP) begin
      o_ready = 1'b1;
      o_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_letc_mtimer.sv
// Scoreboard bench for letc_mtimer: two instances (PRESCALE 1 and 4) share one bus and are
// checked against a cycle-level arithmetic model of mtime/mtimecmp kept in the bench.
`timescale 1ns/1ps
module tb_letc_mtimer;

  localparam int          NI  = 2;
  localparam int unsigned PS0 = 1;
  localparam int unsigned PS1 = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wen   = 1'b0;
  logic [3:0]  addr  = '0;
  logic [31:0] wdata = '0;
`ifdef LETC_MTIMER_DBG_HALT_EN
  logic        halt  = 1'b0;
`endif
  logic [NI-1:0] ready;
  logic [NI-1:0] irq;
  logic [31:0]   rdata [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  letc_mtimer #(.PRESCALE(PS0), .MTIME_RST(64'h0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef LETC_MTIMER_DBG_HALT_EN
    .i_dbg_halt(halt),
`endif
    .i_valid(valid), .o_ready(ready[0]), .i_wen_nren(wen), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata[0]), .o_timer_irq_pending(irq[0])
  );

  letc_mtimer #(.PRESCALE(PS1), .MTIME_RST(64'h0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef LETC_MTIMER_DBG_HALT_EN
    .i_dbg_halt(halt),
`endif
    .i_valid(valid), .o_ready(ready[1]), .i_wen_nren(wen), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata[1]), .o_timer_irq_pending(irq[1])
  );

  // ---------------- reference model ----------------
  logic [63:0] m_mtime [NI];
  logic [63:0] m_cmp   [NI];
  int unsigned m_run   [NI];
  logic        m_irq   [NI];
  int unsigned cyc;

  function automatic int unsigned ps_of(input int k);
    return (k == 0) ? PS0 : PS1;
  endfunction

  function automatic logic halt_now();
`ifdef LETC_MTIMER_DBG_HALT_EN
    return halt;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a[1:0] == 2'b00) begin
      case (a[3:2])
        2'd0: r = m_mtime[k][31:0];
        2'd1: r = m_mtime[k][63:32];
        2'd2: r = m_cmp[k][31:0];
        default: r = m_cmp[k][63:32];
      endcase
    end
    return r;
  endfunction

  // The bus holds valid across exactly one rising edge per request, so a write lands there.
  initial begin
    cyc = 0;
    for (int k = 0; k < NI; k++) begin
      m_mtime[k] = '0; m_cmp[k] = '1; m_run[k] = 0; m_irq[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          m_mtime[k] = '0; m_cmp[k] = '1; m_run[k] = 0; m_irq[k] = 1'b0;
        end else begin
          logic        ir;
          logic        tk;
          logic [63:0] nt;
          ir = (m_mtime[k] >= m_cmp[k]);
          tk = 1'b0;
          if (!halt_now()) begin
            m_run[k]++;
            tk = ((m_run[k] % ps_of(k)) == 0);
          end
          nt = m_mtime[k] + (tk ? 64'd1 : 64'd0);
          if (valid && wen && addr[1:0] == 2'b00) begin
            case (addr[3:2])
              2'd0: nt[31:0] = wdata;
              2'd1: nt[63:32] = wdata;
              2'd2: m_cmp[k][31:0] = wdata;
              default: m_cmp[k][63:32] = wdata;
            endcase
          end
          m_mtime[k] = nt;
          m_irq[k]   = ir;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic                 rd;
    logic [NI-1:0][31:0]  d;
    int unsigned          due;
  } exp_t;

  exp_t sb[$];

  function automatic void chk(input string nm, input int k, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < NI; k++) begin
          chk("rst_ready", k, 64'(ready[k]), 64'd0);
          chk("rst_irq",   k, 64'(irq[k]),   64'd0);
          chk("rst_rdata", k, 64'(rdata[k]), 64'd0);
        end
      end else begin
        for (int k = 0; k < NI; k++) chk("irq", k, 64'(irq[k]), 64'(m_irq[k]));
        if (ready != '0) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ready cyc=%0d got=%b want=00", cyc, ready);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", 0, 64'(cyc), 64'(e.due));
            for (int k = 0; k < NI; k++) begin
              chk("ready", k, 64'(ready[k]), 64'd1);
              if (e.rd) chk("rdata", k, 64'(rdata[k]), 64'(e.d[k]));
            end
          end
        end else begin
          for (int k = 0; k < NI; k++) chk("idle_rdata", k, 64'(rdata[k]), 64'd0);
          if (sb.size() != 0 && cyc > sb[0].due) begin
            total++; bad++;
            $display("FAIL missing_ready cyc=%0d got=none want=cyc%0d", cyc, sb[0].due);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic w, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    valid = 1'b1; wen = w; addr = a; wdata = d;
    e.rd  = !w;
    e.due = cyc + 1;
    for (int k = 0; k < NI; k++) e.d[k] = w ? 32'd0 : model_read(k, a);
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready[0]) break;
    end
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;

    // free-running reads after reset, compare registers read as all ones
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 4'h0, '0);
      req(1'b0, 4'h4, '0);
    end
    req(1'b0, 4'h8, '0);
    req(1'b0, 4'hC, '0);
    idle(20);
    req(1'b0, 4'h0, '0);

    // compare at 0x20: irq rises, then clears when cmp hi is raised
    do_reset();
    req(1'b1, 4'h8, 32'h20);
    req(1'b1, 4'hC, 32'h0);
    idle(45);
    req(1'b0, 4'h0, '0);
    req(1'b1, 4'hC, 32'h1);
    idle(3);

    // carry between halves and 64-bit wrap
    req(1'b1, 4'h4, 32'h0);
    req(1'b1, 4'h0, 32'hFFFF_FFFF);
    req(1'b0, 4'h4, '0);
    req(1'b0, 4'h0, '0);
    req(1'b1, 4'h4, 32'hFFFF_FFFF);
    req(1'b1, 4'h0, 32'hFFFF_FFFC);
    req(1'b0, 4'h0, '0);
    req(1'b0, 4'h4, '0);
    req(1'b0, 4'h0, '0);

    // lo write on a tick edge, misaligned offsets
    req(1'b1, 4'h0, 32'hFFFF_FFFE);
    req(1'b1, 4'h0, 32'h0000_1234);
    req(1'b0, 4'h4, '0);
    req(1'b0, 4'h6, '0);
    req(1'b1, 4'h5, 32'hDEAD_BEEF);
    req(1'b0, 4'h1, '0);
    req(1'b0, 4'h0, '0);

    // reset during the response cycle: no ready pulse may appear
    @(negedge clk);
    valid = 1'b1; wen = 1'b0; addr = 4'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    req(1'b0, 4'h0, '0);

`ifdef LETC_MTIMER_DBG_HALT_EN
    // halt freezes mtime; compare writes still drive the interrupt
    @(negedge clk);
    halt = 1'b1;
    req(1'b1, 4'h8, 32'h0);
    req(1'b1, 4'hC, 32'h0);
    idle(10);
    req(1'b0, 4'h0, '0);
    req(1'b1, 4'hC, 32'h5);
    req(1'b0, 4'h0, '0);
    @(negedge clk);
    halt = 1'b0;
    req(1'b0, 4'h0, '0);
`endif

    // randomized traffic with compare values kept near the running count
    for (int n = 0; n < 250; n++) begin
      logic [3:0]  a;
      logic        w;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      w = 1'($urandom_range(0, 1));
      case (a[3:2])
        2'd0: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'($urandom_range(0, 200));
        2'd1: d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1));
        2'd2: d = m_mtime[0][31:0] + 32'($urandom_range(0, 40));
        default: d = m_mtime[0][63:32] + 32'($urandom_range(0, 1));
      endcase
`ifdef LETC_MTIMER_DBG_HALT_EN
      halt = ($urandom_range(0, 5) == 0);
`endif
      req(w, a, d);
      idle(int'($urandom_range(0, 2)));
    end
`ifdef LETC_MTIMER_DBG_HALT_EN
    halt = 1'b0;
`endif

    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/letc_mtimer.md
Name: letc_mtimer

Overview:
- Machine timer (mtime/mtimecmp) peripheral that produces the core's i_timer_irq_pending input; sits directly upstream of the core in the SoC.
- 64-bit free-running counter and 64-bit compare register, accessed through the core's word-wide valid/ready memory-request handshake (same request fields the core's memory path issues).
- Level interrupt out; software clears it by rewriting mtimecmp or mtime.

Parameters:
- PRESCALE, 1, input clocks per mtime increment (legal range 1..65535; 1 = increment every cycle).
- MTIME_RST, 64'h0, reset value of mtime.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid; held high with fields stable until o_ready
- o_ready  out  1  one-cycle pulse: request complete (rdata valid on reads)
- i_wen_nren  in  1  1 = write, 0 = read
- i_addr  in  4  byte offset: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32]
- i_wdata  in  32  write data
- o_rdata  out  32  read data; valid only when o_ready = 1, else 0
- o_timer_irq_pending  out  1  level: registered (mtime >= mtimecmp)

Behaviour:
- Reset: one clock (i_clk); asynchronous, active-low reset (i_rst_n). While reset is asserted: mtime = MTIME_RST, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescale counter = 0, o_ready = 0, o_rdata = 0, o_timer_irq_pending = 0, FSM = IDLE.
- Prescaler: 16-bit counter; tick when count == PRESCALE-1, then count wraps to 0. With PRESCALE = 1, tick every cycle.
- mtime increments by 1 on each tick and wraps 2^64-1 -> 0 silently.
- Bus FSM:
  - IDLE: on i_valid, perform the access this cycle, go to RESP.
  - RESP: o_ready = 1 (and o_rdata for reads) for exactly one cycle, then IDLE. Fixed latency: o_ready 1 cycle after i_valid is sampled.
  - Back-to-back requests complete at 1 request per 2 cycles.
- Reads sample the register value at the IDLE-cycle edge, i.e. the value before any same-cycle tick.
- Writes replace the addressed 32-bit half only; the other half is unchanged. No carry handling between halves. Software writes mtime lo to 0, then hi, then lo.
- Write to an mtime half in the same cycle as a tick: the written half takes i_wdata; the untouched half takes its incremented-value bits. Write wins for its half.
- i_addr[1:0] != 0 or an unused offset: read returns 0, write is ignored, o_ready still pulses (no error signalling).
- Interrupt: o_timer_irq_pending registered from the post-update mtime/mtimecmp (unsigned 64-bit >=). It reflects a write or tick 1 cycle after the edge where the register changes.
- Reset asserted mid-request: FSM returns to IDLE immediately, no o_ready pulse; the requester must reissue.

Optional Feature:
- Macro LETC_MTIMER_DBG_HALT_EN.
- Defined: adds port i_dbg_halt (in, 1). While high, prescaler and mtime hold; bus writes and interrupt evaluation continue normally.
- Undefined: no port; the counter always runs.

Test Plan:
- Reset then idle, PRESCALE=1 -> after reset release, mtime reads N-1 at the cycle N reads are issued; o_timer_irq_pending stays 0 (mtimecmp all ones).
- Write mtimecmp lo=0x20, hi=0; mtime runs from 0 -> o_timer_irq_pending rises 1 cycle after mtime becomes 0x20; writing mtimecmp hi=1 drops it 1 cycle after the write edge.
- Write mtime lo=0xFFFF_FFFF, hi=0, PRESCALE=1 -> next tick reads back hi=1, lo=0 (carry within the 64-bit counter); set mtime to all ones -> wraps to 0.
- PRESCALE=4 -> mtime increments every 4th cycle; 40 cycles after reset, reads 10 (±1 for read timing).
- Write to mtime lo coincident with a tick -> lo = written value, hi = incremented hi; read of offset 0x6 -> rdata 0, o_ready pulses; reset asserted during RESP -> no o_ready pulse.
- LETC_MTIMER_DBG_HALT_EN defined, i_dbg_halt=1 for 10 cycles -> mtime unchanged; a mtimecmp write during halt still updates the interrupt.
